// File: rtl/d_mem_arb_if.sv
// Request/response and data-memory signals of the two-requester data memory arbiter.
// master: requesters plus memory side; slave: the arbiter itself.
interface d_mem_arb_if #(
    parameter int unsigned BUS_WIDTH = 32
);
    logic                 req_0;
    logic                 req_1;
    logic [BUS_WIDTH-1:0] addr_0;
    logic [BUS_WIDTH-1:0] addr_1;
    logic [BUS_WIDTH-1:0] wr_data_0;
    logic [BUS_WIDTH-1:0] wr_data_1;
    logic                 wr_en_0;
    logic                 wr_en_1;
    logic [1:0]           size_0;
    logic [1:0]           size_1;
    logic                 sz_ex_0;
    logic                 sz_ex_1;
    logic                 gnt_0;
    logic                 gnt_1;
    logic                 done_0;
    logic                 done_1;
    logic [BUS_WIDTH-1:0] rd_data_0;
    logic [BUS_WIDTH-1:0] rd_data_1;
    logic [BUS_WIDTH-1:0] d_mem_address;
    logic [BUS_WIDTH-1:0] d_mem_wr_data;
    logic                 d_mem_wr_en;
    logic [1:0]           d_mem_size;
    logic                 d_mem_sz_ex;
    logic [BUS_WIDTH-1:0] d_mem_rd_data;

    modport master (
        output req_0, req_1, addr_0, addr_1, wr_data_0, wr_data_1,
        output wr_en_0, wr_en_1, size_0, size_1, sz_ex_0, sz_ex_1,
        input  gnt_0, gnt_1, done_0, done_1, rd_data_0, rd_data_1,
        input  d_mem_address, d_mem_wr_data, d_mem_wr_en, d_mem_size, d_mem_sz_ex,
        output d_mem_rd_data
    );

    modport slave (
        input  req_0, req_1, addr_0, addr_1, wr_data_0, wr_data_1,
        input  wr_en_0, wr_en_1, size_0, size_1, sz_ex_0, sz_ex_1,
        output gnt_0, gnt_1, done_0, done_1, rd_data_0, rd_data_1,
        output d_mem_address, d_mem_wr_data, d_mem_wr_en, d_mem_size, d_mem_sz_ex,
        input  d_mem_rd_data
    );
endinterface

// File: rtl/d_mem_arb.sv
// Two-requester data memory arbiter: grant in IDLE, one memory access in ACCESS, done next cycle.
// Define ARB_ROUND_ROBIN_EN for alternating grants on conflict; default is fixed priority to 0.
module d_mem_arb #(
    parameter int unsigned BUS_WIDTH          = 32,
    parameter int unsigned MEM_MAP_IO_ADDRESS = 64
) (
    input  logic        clk,
    input  logic        rst,
    d_mem_arb_if.slave  bus
);

    // IO decode happens downstream; the address is passed through untouched.
    localparam int unsigned unused_io_address = MEM_MAP_IO_ADDRESS;

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    state_e               state_q, state_d;
    logic                 last_q;
    logic                 idx_q;
    logic [BUS_WIDTH-1:0] addr_q;
    logic [BUS_WIDTH-1:0] wr_data_q;
    logic                 wr_en_q;
    logic [1:0]           size_q;
    logic                 sz_ex_q;
    logic [1:0]           done_q;
    logic [BUS_WIDTH-1:0] rd_data_0_q;
    logic [BUS_WIDTH-1:0] rd_data_1_q;

    logic any_req;
    logic sel;
    logic grant;

    assign any_req = bus.req_0 | bus.req_1;

`ifdef ARB_ROUND_ROBIN_EN
    // On conflict serve whoever was not granted last; otherwise the sole requester.
    assign sel = (bus.req_0 & bus.req_1) ? ~last_q : bus.req_1;
`else
    logic unused_last;
    assign unused_last = last_q;
    assign sel = ~bus.req_0;
`endif

    always_comb begin
        state_d           = state_q;
        grant             = 1'b0;
        bus.gnt_0         = 1'b0;
        bus.gnt_1         = 1'b0;
        bus.d_mem_address = '0;
        bus.d_mem_wr_data = '0;
        bus.d_mem_wr_en   = 1'b0;
        bus.d_mem_size    = 2'b00;
        bus.d_mem_sz_ex   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (any_req && !rst) begin
                    grant     = 1'b1;
                    bus.gnt_0 = ~sel;
                    bus.gnt_1 = sel;
                    state_d   = StAccess;
                end
            end
            StAccess: begin
                bus.d_mem_address = addr_q;
                bus.d_mem_wr_data = wr_data_q;
                // Reset during ACCESS drops an in-flight store.
                bus.d_mem_wr_en   = wr_en_q & ~rst;
                bus.d_mem_size    = size_q;
                bus.d_mem_sz_ex   = sz_ex_q;
                state_d           = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            last_q      <= 1'b1;
            idx_q       <= 1'b0;
            addr_q      <= '0;
            wr_data_q   <= '0;
            wr_en_q     <= 1'b0;
            size_q      <= 2'b00;
            sz_ex_q     <= 1'b0;
            done_q      <= 2'b00;
            rd_data_0_q <= '0;
            rd_data_1_q <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= 2'b00;
            if (grant) begin
                idx_q     <= sel;
                last_q    <= sel;
                addr_q    <= sel ? bus.addr_1    : bus.addr_0;
                wr_data_q <= sel ? bus.wr_data_1 : bus.wr_data_0;
                wr_en_q   <= sel ? bus.wr_en_1   : bus.wr_en_0;
                size_q    <= sel ? bus.size_1    : bus.size_0;
                sz_ex_q   <= sel ? bus.sz_ex_1   : bus.sz_ex_0;
            end
            if (state_q == StAccess) begin
                done_q[idx_q] <= 1'b1;
                if (!wr_en_q) begin
                    if (idx_q) rd_data_1_q <= bus.d_mem_rd_data;
                    else       rd_data_0_q <= bus.d_mem_rd_data;
                end
            end
        end
    end

    assign bus.done_0    = done_q[0];
    assign bus.done_1    = done_q[1];
    assign bus.rd_data_0 = rd_data_0_q;
    assign bus.rd_data_1 = rd_data_1_q;

endmodule

// File: tb/tb_d_mem_arb.sv
// Directed self-checking bench for d_mem_arb with a byte-addressed memory model.
module tb_d_mem_arb;

    logic clk = 1'b0;
    logic rst;
    logic preload;
    int   checks = 0;
    int   errors = 0;

    d_mem_arb_if #(.BUS_WIDTH(32)) bus ();

    d_mem_arb #(.BUS_WIDTH(32), .MEM_MAP_IO_ADDRESS(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:255];
    logic [7:0]  ma;
    logic [31:0] mw;
    logic [31:0] mrd;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[8'h08] <= 8'h80;
            mem[8'h20] <= 8'hA5;
            mem[8'h30] <= 8'h44;
            mem[8'h31] <= 8'h33;
            mem[8'h32] <= 8'h22;
            mem[8'h33] <= 8'h11;
        end else if (bus.d_mem_wr_en) begin
            mem[bus.d_mem_address[7:0]] <= bus.d_mem_wr_data[7:0];
            if (bus.d_mem_size != 2'd0)
                mem[bus.d_mem_address[7:0] + 8'd1] <= bus.d_mem_wr_data[15:8];
            if (bus.d_mem_size == 2'd2) begin
                mem[bus.d_mem_address[7:0] + 8'd2] <= bus.d_mem_wr_data[23:16];
                mem[bus.d_mem_address[7:0] + 8'd3] <= bus.d_mem_wr_data[31:24];
            end
        end
    end

    always_comb begin
        ma  = bus.d_mem_address[7:0];
        mw  = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};
        mrd = mw;
        case (bus.d_mem_size)
            2'd0: mrd = bus.d_mem_sz_ex ? {{24{mw[7]}}, mw[7:0]} : {24'h0, mw[7:0]};
            2'd1: mrd = bus.d_mem_sz_ex ? {{16{mw[15]}}, mw[15:0]} : {16'h0, mw[15:0]};
            default: mrd = mw;
        endcase
        bus.d_mem_rd_data = mrd;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_reqs();
        bus.req_0 = 1'b0;
        bus.req_1 = 1'b0;
    endtask

    task automatic drive(input int r, input logic [31:0] a, input logic [31:0] wd,
                         input logic we, input logic [1:0] sz, input logic sx);
        if (r == 0) begin
            bus.req_0 = 1'b1; bus.addr_0 = a; bus.wr_data_0 = wd;
            bus.wr_en_0 = we; bus.size_0 = sz; bus.sz_ex_0 = sx;
        end else begin
            bus.req_1 = 1'b1; bus.addr_1 = a; bus.wr_data_1 = wd;
            bus.wr_en_1 = we; bus.size_1 = sz; bus.sz_ex_1 = sx;
        end
    endtask

    logic rr;
    logic exp_g0;
    logic exp_g1;

    initial begin
`ifdef ARB_ROUND_ROBIN_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        rst = 1'b1;
        preload = 1'b1;
        idle_reqs();
        drive(1, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
        idle_reqs();
        drive(0, 32'h10, 32'hDEADBEEF, 1'b1, 2'd2, 1'b0);
        step();
        step();
        sample();
        check("rst_gnt_0", {31'b0, bus.gnt_0}, 32'd0);
        check("rst_done_0", {31'b0, bus.done_0}, 32'd0);
        check("rst_done_1", {31'b0, bus.done_1}, 32'd0);
        check("rst_rd_data_0", bus.rd_data_0, 32'h0);
        check("rst_rd_data_1", bus.rd_data_1, 32'h0);
        check("rst_wr_en", {31'b0, bus.d_mem_wr_en}, 32'd0);

        // Store then load, requester 0
        step(); rst = 1'b0; preload = 1'b0;
        sample();
        check("st_gnt_0", {31'b0, bus.gnt_0}, 32'd1);
        check("st_gnt_1", {31'b0, bus.gnt_1}, 32'd0);
        check("st_idle_wr_en", {31'b0, bus.d_mem_wr_en}, 32'd0);
        check("st_idle_addr", bus.d_mem_address, 32'h0);
        step(); idle_reqs();
        sample();
        check("st_acc_wr_en", {31'b0, bus.d_mem_wr_en}, 32'd1);
        check("st_acc_addr", bus.d_mem_address, 32'h10);
        check("st_acc_wdata", bus.d_mem_wr_data, 32'hDEADBEEF);
        check("st_acc_size", {30'b0, bus.d_mem_size}, 32'd2);
        check("st_acc_gnt_0", {31'b0, bus.gnt_0}, 32'd0);
        check("st_acc_done_0", {31'b0, bus.done_0}, 32'd0);
        step(); drive(0, 32'h10, 32'h0, 1'b0, 2'd2, 1'b0);
        sample();
        check("st_done_0", {31'b0, bus.done_0}, 32'd1);
        check("st_rd_data_0_kept", bus.rd_data_0, 32'h0);
        check("st_done_wr_en", {31'b0, bus.d_mem_wr_en}, 32'd0);
        check("ld_gnt_with_done", {31'b0, bus.gnt_0}, 32'd1);
        step(); idle_reqs();
        sample();
        check("ld_acc_addr", bus.d_mem_address, 32'h10);
        check("ld_acc_wr_en", {31'b0, bus.d_mem_wr_en}, 32'd0);
        check("ld_acc_done_0", {31'b0, bus.done_0}, 32'd0);
        step();
        sample();
        check("ld_done_0", {31'b0, bus.done_0}, 32'd1);
        check("ld_rd_data_0", bus.rd_data_0, 32'hDEADBEEF);

        // Signed byte load via requester 1
        step(); drive(1, 32'h8, 32'h0, 1'b0, 2'd0, 1'b1);
        sample();
        check("sb_gnt_1", {31'b0, bus.gnt_1}, 32'd1);
        check("sb_gnt_0", {31'b0, bus.gnt_0}, 32'd0);
        step(); idle_reqs();
        sample();
        check("sb_acc_sz_ex", {31'b0, bus.d_mem_sz_ex}, 32'd1);
        check("sb_acc_size", {30'b0, bus.d_mem_size}, 32'd0);
        check("sb_acc_addr", bus.d_mem_address, 32'h8);
        step();
        sample();
        check("sb_done_1", {31'b0, bus.done_1}, 32'd1);
        check("sb_done_0", {31'b0, bus.done_0}, 32'd0);
        check("sb_rd_data_1", bus.rd_data_1, 32'hFFFFFF80);
        check("sb_rd_data_0_kept", bus.rd_data_0, 32'hDEADBEEF);

        // Payload change after grant must not affect the access
        step(); drive(1, 32'h30, 32'h0, 1'b0, 2'd2, 1'b0);
        sample();
        check("pc_gnt_1", {31'b0, bus.gnt_1}, 32'd1);
        step(); bus.addr_1 = 32'h40; idle_reqs();
        sample();
        check("pc_acc_addr", bus.d_mem_address, 32'h30);
        step();
        sample();
        check("pc_rd_data_1", bus.rd_data_1, 32'h11223344);

        // Reset while a store is in ACCESS
        step(); drive(0, 32'h20, 32'h55, 1'b1, 2'd0, 1'b0);
        sample();
        check("ra_gnt_0", {31'b0, bus.gnt_0}, 32'd1);
        step(); rst = 1'b1; idle_reqs();
        sample();
        check("ra_wr_en_forced", {31'b0, bus.d_mem_wr_en}, 32'd0);
        check("ra_gnt_0_forced", {31'b0, bus.gnt_0}, 32'd0);
        step(); rst = 1'b0; drive(0, 32'h20, 32'h0, 1'b0, 2'd0, 1'b0);
        sample();
        check("ra_no_done_0", {31'b0, bus.done_0}, 32'd0);
        check("ra_rd_data_0_rst", bus.rd_data_0, 32'h0);
        check("ra_first_gnt", {31'b0, bus.gnt_0}, 32'd1);
        step(); idle_reqs();
        sample();
        check("ra_ld_addr", bus.d_mem_address, 32'h20);
        step();
        sample();
        check("ra_ld_done_0", {31'b0, bus.done_0}, 32'd1);
        check("ra_ld_rd_data_0", bus.rd_data_0, 32'hA5);

        // Both requesters held after reset
        step(); rst = 1'b1;
        drive(0, 32'h0, 32'h0, 1'b0, 2'd2, 1'b0);
        drive(1, 32'h4, 32'h0, 1'b0, 2'd2, 1'b0);
        step(); rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            sample();
            exp_g0 = (k % 2 == 0) && (!rr || (k % 4 == 0));
            exp_g1 = (k % 2 == 0) && rr && (k % 4 == 2);
            check($sformatf("conf_gnt_0_c%0d", k), {31'b0, bus.gnt_0}, {31'b0, exp_g0});
            check($sformatf("conf_gnt_1_c%0d", k), {31'b0, bus.gnt_1}, {31'b0, exp_g1});
            step();
        end
        idle_reqs();
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/d_mem_arb.md
D_MEM_ARB -- requirements
Module: d_mem_arb

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 32, data/address width.
REQ-002 SHALL have parameter MEM_MAP_IO_ADDRESS, default 64, address passed through unchanged; no special handling in this block.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_0 / req_1  input  1  access request, requester 0 (core) / requester 1 (loader/debug).
REQ-006 addr_0 / addr_1  input  BUS_WIDTH  byte address of request.
REQ-007 wr_data_0 / wr_data_1  input  BUS_WIDTH  store data.
REQ-008 wr_en_0 / wr_en_1  input  1  1 = store, 0 = load.
REQ-009 size_0 / size_1  input  2  access size, forwarded to d_mem_size.
REQ-010 sz_ex_0 / sz_ex_1  input  1  0 = zero extend, 1 = sign extend.
REQ-011 gnt_0 / gnt_1  output  1  combinational one-cycle acceptance pulse.
REQ-012 done_0 / done_1  output  1  registered one-cycle completion pulse.
REQ-013 rd_data_0 / rd_data_1  output  BUS_WIDTH  registered load data.
REQ-014 d_mem_address, d_mem_wr_data  output  BUS_WIDTH  to data memory.
REQ-015 d_mem_wr_en  output  1; d_mem_size  output  2; d_mem_sz_ex  output  1  to data memory.
REQ-016 d_mem_rd_data  input  BUS_WIDTH  combinational read data from data memory.

Function
REQ-017 SHALL implement FSM with states IDLE and ACCESS.
REQ-018 In IDLE with any req_x high and rst low, SHALL assert exactly one gnt_x that cycle (N), latch that requester's addr/wr_data/wr_en/size/sz_ex and its index, and go to ACCESS.
REQ-019 In ACCESS (cycle N+1), SHALL drive d_mem_* from latched command, assert d_mem_wr_en only for stores, capture d_mem_rd_data for loads, return to IDLE.
REQ-020 In cycle N+2, SHALL pulse done_x of served requester for one cycle; rd_data_x SHALL then hold captured data for loads and SHALL remain unchanged for stores.
REQ-021 gnt_0 and gnt_1 SHALL be 0 in ACCESS; throughput is one access per 2 cycles; a new grant is allowed in the same cycle as a done pulse.
REQ-022 Requesters hold req and payload stable until gnt; payload changes after gnt SHALL not affect the access in flight.
REQ-023 In IDLE, d_mem_address, d_mem_wr_data, d_mem_size and d_mem_sz_ex SHALL be 0 and d_mem_wr_en SHALL be 0.
REQ-024 Arbitration winner SHALL be per REQ-030/031; the sole requester always wins.
REQ-025 SHALL record last-granted index on every grant.

Reset
REQ-026 With rst high at a posedge: state IDLE, done_0/1 = 0, rd_data_0/1 = 0, last-granted = 1.
REQ-027 gnt_0/1 and d_mem_wr_en SHALL be forced 0 combinationally whenever rst is high, including rst asserted in ACCESS, so that an in-flight store is dropped and no done is produced.
REQ-028 First cycle after rst deasserts SHALL be able to grant.

Configuration
REQ-029 Macro ARB_ROUND_ROBIN_EN selects the policy.
REQ-030 Defined: on simultaneous req_0 and req_1, grant the requester not in last-granted (alternation).
REQ-031 Undefined: fixed priority, requester 0 always wins on conflict; last-granted is still recorded but unused.

Verification
REQ-032 Store then load, requester 0: addr 0x10, wr_data 0xDEADBEEF, size word, then load 0x10 -> gnt_0 at N, d_mem_wr_en high at N+1 only, done_0 at N+2; load gives rd_data_0 = 0xDEADBEEF with done_0.
REQ-033 Simultaneous requests, both held for 4 grants after reset -> with macro, grants 0,1,0,1 at cycles 0,2,4,6; without macro, gnt_0 on all four and gnt_1 never.
REQ-034 Reset in ACCESS: store 0x55 to 0x20 granted at N, rst high at N+1 -> d_mem_wr_en 0 at N+1, no done_0; a later load of 0x20 returns the prior content.
REQ-035 Payload change after grant: req_1 load 0x30 granted, addr_1 changed to 0x40 at N+1 -> d_mem_address = 0x30 at N+1.
REQ-036 Signed byte load via requester 1: memory 0x80 at 0x8, size byte, sz_ex 1 -> d_mem_sz_ex 1 at N+1, rd_data_1 = 0xFFFFFF80 at N+2; rd_data_0 unchanged.
